// File: rtl/calc_pkg.sv
// Shared FSM state type and active-low seven-segment glyphs (gfedcba) for the result display.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SHOW = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 3-bit magnitude to active-low seven-segment glyph.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [2:0] mag_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (mag_i)
            3'd0: seg_o = SEG_0;
            3'd1: seg_o = SEG_1;
            3'd2: seg_o = SEG_2;
            3'd3: seg_o = SEG_3;
            3'd4: seg_o = SEG_4;
            3'd5: seg_o = SEG_5;
            3'd6: seg_o = SEG_6;
            3'd7: seg_o = SEG_7;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/calc_result_display.sv
// Accepts sign-magnitude results, holds each for a minimum time and multiplexes
// sign/units digits onto a two-digit active-low seven-segment display.
module calc_result_display
    import calc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 1000,
    parameter int unsigned MIN_HOLD    = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic [3:0] res,
    input  logic       ovf,
    input  logic       clear,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int unsigned REF_W  = $clog2(REFRESH_DIV);
    localparam int unsigned HOLD_W = $clog2(MIN_HOLD);
    localparam logic [REF_W-1:0]  REF_MAX   = REF_W'(REFRESH_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);

    state_e             state_q, state_d;
    logic [3:0]         res_q, res_d;
    logic               ovf_q, ovf_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [REF_W-1:0]   ref_q, ref_d;
    logic               sel_q, sel_d;
    logic               ready_q, ready_d;
    logic [1:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic [6:0]         units_glyph;
    logic               xfer;

    seg7_decode u_seg7_decode (
        .mag_i (res_d[2:0]),
        .seg_o (units_glyph)
    );

    // Display outputs are computed from next-state values so the registered
    // outputs line up with the state/select they describe.
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        hold_d  = hold_q;
        ref_d   = ref_q;
        sel_d   = sel_q;
        xfer    = res_valid && (state_q != HOLD);

        if (clear) begin
            state_d = IDLE;
            hold_d  = '0;
            ref_d   = '0;
            sel_d   = 1'b0;
        end else if (xfer) begin
            state_d = HOLD;
            res_d   = res;
            ovf_d   = ovf;
            hold_d  = HOLD_LOAD;
            ref_d   = '0;
            sel_d   = 1'b0;
        end else begin
            if (state_q == HOLD) begin
                if (hold_q == '0) begin
                    state_d = SHOW;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            if (state_q != IDLE) begin
                if (ref_q == REF_MAX) begin
                    ref_d = '0;
                    sel_d = ~sel_q;
                end else begin
                    ref_d = ref_q + 1'b1;
                end
            end
        end

        ready_d = (state_d != HOLD);
        an_d    = 2'b11;
        seg_d   = SEG_BLANK;
        if (state_d != IDLE) begin
            an_d = sel_d ? 2'b01 : 2'b10;
            if (ovf_d) begin
                seg_d = sel_d ? SEG_BLANK : SEG_E;
            end else if (!sel_d) begin
                seg_d = units_glyph;
            end else if (res_d[3] && (res_d[2:0] != 3'd0)) begin
                seg_d = SEG_MINUS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= '0;
            ref_q   <= '0;
            sel_q   <= 1'b0;
            ready_q <= 1'b1;
            an_q    <= 2'b11;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
            ref_q   <= ref_d;
            sel_q   <= sel_d;
            ready_q <= ready_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign res_ready = ready_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_calc_result_display.sv
// Directed self-checking bench for calc_result_display with REFRESH_DIV=4, MIN_HOLD=8.
module tb_calc_result_display;

    logic       clk;
    logic       rst_n;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res;
    logic       ovf;
    logic       clear;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int errors = 0;

    calc_result_display #(
        .REFRESH_DIV (4),
        .MIN_HOLD    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res       (res),
        .ovf       (ovf),
        .clear     (clear),
        .seg       (seg),
        .an        (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares {res_ready, an, seg} against an expected packed value.
    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {res_ready, an, seg};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed ready/an/seg=%b/%b/%b expected %b/%b/%b",
                   tag, obs[9], obs[8:7], obs[6:0], exp[9], exp[8:7], exp[6:0]);
        end
    endtask

    // Expected output k cycles after a transfer edge (k=0 sampled right after it).
    task automatic chk_slot(input string tag, input int k,
                            input logic [6:0] units, input logic [6:0] sgn);
        logic       exp_sel;
        logic       exp_rdy;
        exp_sel = ((k / 4) % 2) == 1;
        exp_rdy = (k >= 8);
        chk($sformatf("%s k=%0d", tag, k),
            {exp_rdy, (exp_sel ? 2'b01 : 2'b10), (exp_sel ? sgn : units)});
    endtask

    localparam logic [9:0] IDLE_OUT = {1'b1, 2'b11, 7'b1111111};

    initial begin
        rst_n     = 1'b0;
        res_valid = 1'b0;
        res       = 4'b0000;
        ovf       = 1'b0;
        clear     = 1'b0;
        step();
        step();
        chk("reset", IDLE_OUT);

        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("idle %0d", i), IDLE_OUT);
        end

        // -5: units '5', sign '-'
        res_valid = 1'b1;
        res       = 4'b1101;
        step();
        res_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_slot("neg5", k, 7'b0010010, 7'b0111111);
            step();
        end

        // Negative zero displays as plain 0 (accepted in SHOW)
        res_valid = 1'b1;
        res       = 4'b1000;
        step();
        res_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_slot("negzero", k, 7'b1000000, 7'b1111111);
            step();
        end

        // Overflow shows E regardless of res
        res_valid = 1'b1;
        res       = 4'b0011;
        ovf       = 1'b1;
        step();
        res_valid = 1'b0;
        ovf       = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk_slot("ovf", k, 7'b0000110, 7'b1111111);
            step();
        end

        // Transfer +2, then hold res_valid with 7 throughout HOLD
        res_valid = 1'b1;
        res       = 4'b0010;
        step();
        res       = 4'b0111;
        for (int k = 0; k < 9; k++) begin
            chk_slot("held", k, 7'b0100100, 7'b1111111);
            step();
        end
        res_valid = 1'b0;
        for (int k = 0; k < 9; k++) begin
            chk_slot("seven", k, 7'b1111000, 7'b1111111);
            step();
        end

        // Now in SHOW: clear beats a simultaneous transfer
        clear     = 1'b1;
        res_valid = 1'b1;
        res       = 4'b1101;
        step();
        clear     = 1'b0;
        res_valid = 1'b0;
        chk("clear", IDLE_OUT);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("post-clear %0d", i), IDLE_OUT);
        end

        // Reset pulse mid-HOLD discards the pending result
        res_valid = 1'b1;
        res       = 4'b1110;
        step();
        res_valid = 1'b0;
        chk_slot("pre-rst", 0, 7'b0000010, 7'b0111111);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("mid-hold reset", IDLE_OUT);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("post-rst %0d", i), IDLE_OUT);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/calc_result_display.md
CALC_RESULT_DISPLAY -- requirements
Module: calc_result_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 1000: clock cycles per digit-multiplex slot (>=2).
REQ-002 SHALL have parameter MIN_HOLD, default 50000: minimum cycles an accepted result is shown before a new one is accepted (>=2).
REQ-003 SHALL have port clk, input, 1: single clock; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-005 SHALL have port res_valid, input, 1: a result is offered on res/ovf.
REQ-006 SHALL have port res_ready, output, 1: block can accept a result.
REQ-007 SHALL have port res, input, 4: sign-magnitude result, bit 3 = sign, bits 2:0 = magnitude 0..7.
REQ-008 SHALL have port ovf, input, 1: overflow flag accompanying res.
REQ-009 SHALL have port clear, input, 1: blank the display and return to idle.
REQ-010 SHALL have port seg, output, 7: segments gfedcba, active-low.
REQ-011 SHALL have port an, output, 2: digit enables, active-low, an[0] = units digit, an[1] = sign digit.

Function
REQ-012 SHALL implement FSM states IDLE, HOLD and SHOW.
REQ-013 IDLE: an=2'b11, seg=7'b1111111, res_ready=1.
REQ-014 Transfer occurs when res_valid && res_ready on a rising edge: res/ovf are registered and the next state is HOLD, with the hold counter loaded to MIN_HOLD-1.
REQ-015 HOLD: res_ready=0; counter decrements each cycle; at 0, next state is SHOW.
REQ-016 SHOW: res_ready=1; a new transfer replaces the stored result and re-enters HOLD.
REQ-017 In HOLD/SHOW, the refresh counter SHALL count 0..REFRESH_DIV-1; on wrap, digit select toggles; an is the active-low one-hot of the select (sel=0 -> an=2'b10).
REQ-018 Units digit SHALL show the magnitude glyph: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000.
REQ-019 Sign digit SHALL show '-' (0111111) when sign=1 and magnitude!=0, otherwise blank (1111111); negative zero displays as "0".
REQ-020 When the stored ovf=1: units digit shows 'E' (0000110) and sign digit is blank, regardless of res.
REQ-021 clear=1 SHALL force IDLE on the next edge, taking priority over a simultaneous transfer (no transfer occurs; res_ready still drives its state value that cycle).
REQ-022 Outputs SHALL be registered; displayed data updates one cycle after transfer; the first slot after transfer starts with sel=0 and the refresh counter at 0.
REQ-023 res_ready SHALL depend only on state, never combinationally on res_valid.

Reset
REQ-024 rst_n=0 at an edge: state=IDLE, res_ready=1, an=2'b11, seg=7'b1111111, sel=0, counters=0, stored res=0, ovf=0.
REQ-025 Reset mid-HOLD or mid-SHOW SHALL abort immediately; the pending result is discarded.

Structure
REQ-026 A shared package calc_pkg SHALL hold the state enum and the segment glyph constants (digits 0-7, MINUS, BLANK, E).
REQ-027 A combinational sub-module seg7_decode (3-bit magnitude -> 7-bit active-low segments) SHALL be instantiated once.
REQ-028 Counter widths SHALL be derived from parameters via $clog2.

Verification (REFRESH_DIV=4, MIN_HOLD=8)
REQ-029 Reset, then idle 10 cycles -> an=11, seg=1111111, res_ready=1 throughout.
REQ-030 Transfer res=4'b1101, ovf=0 -> res_ready=0 for 8 cycles; alternating slots of 4 cycles: an=10 seg=0010010, an=01 seg=0111111.
REQ-031 Transfer res=4'b1000 -> sign slot blank, units slot 1000000.
REQ-032 Transfer with ovf=1, res=4'b0011 -> units slot 0000110, sign slot blank.
REQ-033 res_valid held during HOLD with res=4'b0111 -> not accepted until SHOW; accepted on the first SHOW cycle; display then shows 1111000.
REQ-034 clear and res_valid asserted together in SHOW -> IDLE next cycle, display blank, new value not captured; rst_n pulse mid-HOLD -> IDLE values per REQ-024.
